// File: rtl/challenge_expand.sv
// challenge_expand: expands a challenged-round / unopened-party list into one output beat per round.
// Optional macro CHALLENGE_CHECK_EN adds a one-cycle CHECK state that rejects malformed challenges.
module challenge_expand #(
    parameter int NUM_ROUNDS = 8,
    parameter int NUM_CHAL   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5*NUM_CHAL-1:0] Lc,
    input  logic [5*NUM_CHAL-1:0] Lp,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_round,
    output logic                  out_chal,
    output logic [3:0]            out_party
);
    localparam int         LW         = 5 * NUM_CHAL;
    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

`ifdef CHALLENGE_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd2, DONE = 2'd3} state_t;
`endif

    state_t        state_r, state_next;
    logic [LW-1:0] lc_r, lp_r, lc_next_s, lp_next_s;
    logic [4:0]    round_r, round_next;
    logic          load_s;
    logic [4:0]    beat_s;

    function automatic logic [4:0] entry(input logic [LW-1:0] list, input int k);
        return list[LW-1-5*k -: 5];
    endfunction

    // Descending scan so the lowest-index match overwrites last; out-of-range entries never match.
    function automatic logic [4:0] lookup(input logic [4:0] rnd, input logic [LW-1:0] lc,
                                          input logic [LW-1:0] lp);
        logic       hit;
        logic [3:0] party;
        hit   = 1'b0;
        party = 4'd0;
        for (int k = NUM_CHAL - 1; k >= 0; k--) begin
            if (entry(lc, k) == rnd) begin
                hit   = 1'b1;
                party = lp[LW-2-5*k -: 4];
            end
        end
        return {hit, party};
    endfunction

`ifdef CHALLENGE_CHECK_EN
    logic bad_s;

    function automatic logic challenge_bad(input logic [LW-1:0] lc, input logic [LW-1:0] lp);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_CHAL; i++) begin
            if ({1'b0, entry(lc, i)} >= 6'(NUM_ROUNDS)) bad = 1'b1;
            if (lp[LW-1-5*i]) bad = 1'b1;
            for (int j = i + 1; j < NUM_CHAL; j++) begin
                if (entry(lc, i) == entry(lc, j)) bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign bad_s = challenge_bad(lc_r, lp_r);
`endif

    // Next-state and round-counter logic.
    always_comb begin
        state_next = state_r;
        round_next = round_r;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    round_next = 5'd0;
`ifdef CHALLENGE_CHECK_EN
                    state_next = CHECK;
`else
                    state_next = EMIT;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
`ifdef CHALLENGE_CHECK_EN
            CHECK: begin
                if (bad_s) state_next = DONE;
                else       state_next = EMIT;
            end
`endif
            EMIT: begin
                if (out_ready) begin
                    if (round_r == LAST_ROUND) state_next = DONE;
                    else                       round_next = round_r + 5'd1;
                end else begin
                    state_next = EMIT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view, so the beat tracks a fresh load immediately.
    assign lc_next_s = load_s ? Lc : lc_r;
    assign lp_next_s = load_s ? Lp : lp_r;
    assign beat_s    = lookup(round_next, lc_next_s, lp_next_s);

    // State, latched challenge and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            round_r   <= 5'd0;
            lc_r      <= {LW{1'b0}};
            lp_r      <= {LW{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_round <= 5'd0;
            out_chal  <= 1'b0;
            out_party <= 4'd0;
        end else begin
            state_r   <= state_next;
            round_r   <= round_next;
            if (load_s) begin
                lc_r <= Lc;
                lp_r <= Lp;
            end
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            out_valid <= (state_next == EMIT);
            if (state_next == EMIT) begin
                out_round <= round_next;
                out_chal  <= beat_s[4];
                out_party <= beat_s[3:0];
            end else begin
                out_round <= 5'd0;
                out_chal  <= 1'b0;
                out_party <= 4'd0;
            end
`ifdef CHALLENGE_CHECK_EN
            if (load_s)                 err <= 1'b0;
            else if (state_r == CHECK)  err <= bad_s;
            else                        err <= err;
`else
            err <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_challenge_expand.sv
// Scoreboard bench for challenge_expand: stimulus pushes expected beats/done events, a negedge monitor checks them.
// Vectors follow the CHALLENGE_CHECK_EN setting of the build.
module tb_challenge_expand;
    localparam int NR = 8;
`ifdef CHALLENGE_CHECK_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic [19:0] Lc, Lp;
    logic        busy, done, err, out_valid, out_chal;
    logic [4:0]  out_round;
    logic [3:0]  out_party;

    challenge_expand #(.NUM_ROUNDS(NR), .NUM_CHAL(4)) dut (
        .clk(clk), .reset(reset), .start(start), .Lc(Lc), .Lp(Lp),
        .busy(busy), .done(done), .err(err), .out_valid(out_valid), .out_ready(out_ready),
        .out_round(out_round), .out_chal(out_chal), .out_party(out_party)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic err; int cyc; } done_t;
    logic [9:0] exp_beat[$];
    done_t      exp_done[$];
    int n_cmp = 0, n_bad = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_done(input logic e, input int c);
        done_t d;
        d.err = e;
        d.cyc = c;
        exp_done.push_back(d);
    endtask

    task automatic push_beats(input logic [7:0] mask, input logic [31:0] parties);
        for (int r = 0; r < NR; r++) exp_beat.push_back({5'(r), mask[r], parties[4*r +: 4]});
    endtask

    // Monitor: beats are consumed when valid&ready at the following edge; stalled beats must hold.
    logic       held_v = 1'b0;
    logic [9:0] held_beat;
    always @(negedge clk) begin
        logic [9:0] beat;
        done_t      d;
        beat = {out_round, out_chal, out_party};
        if (!reset && out_valid) begin
            if (held_v) chk("stall_hold", beat, held_beat);
            held_v    = !out_ready;
            held_beat = beat;
            if (out_ready) begin
                if (exp_beat.size() == 0) chk("unexpected_beat", beat, 10'h3FF);
                else chk("beat", beat, exp_beat.pop_front());
            end
        end else begin
            held_v = 1'b0;
        end
        if (!reset && done) begin
            done_cnt++;
            if (exp_done.size() == 0) chk("unexpected_done", done, 1'b0);
            else begin
                d = exp_done.pop_front();
                chk("done_err", err, d.err);
                chk("done_cycle", cyc, d.cyc);
            end
        end
    end

    task automatic kick(input logic [19:0] lc, input logic [19:0] lp, output int c0);
        @(posedge clk); #1;
        Lc = lc; Lp = lp; start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; Lc = 20'hFFFFF; Lp = 20'hFFFFF;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 300) begin @(posedge clk); n++; end
        chk({name, "_completed"}, done_cnt >= target, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_round(input logic [4:0] r, input string name);
        int n = 0;
        while (!(out_valid && out_round == r) && n < 50) begin @(posedge clk); #1; n++; end
        chk(name, out_valid && out_round == r, 1'b1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_err"}, err, 1'b0);
        chk({name, "_valid"}, out_valid, 1'b0);
        chk({name, "_beat"}, {out_round, out_chal, out_party}, 10'd0);
    endtask

    initial begin
        int c0, n, saved;
        reset = 1'b1; start = 1'b0; Lc = 20'd0; Lp = 20'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_state");
        reset = 1'b0;

        // Basic expansion {1,3,5,7}/{2,15,0,9}
        push_beats(8'hAA, 32'h9000_F020);
        kick(20'h08CA7, 20'h13C09, c0);
        push_done(1'b0, c0 + NR + 1 + LAT);
        chk("busy_running", busy, 1'b1);
        wait_done(1, "basic");
        chk("busy_idle", busy, 1'b0);

        // Backpressure: round 3 stalled for 3 cycles
        push_beats(8'hAA, 32'h9000_F020);
        kick(20'h08CA7, 20'h13C09, c0);
        push_done(1'b0, c0 + NR + 1 + LAT + 3);
        wait_round(5'd3, "reach_round3");
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        wait_done(2, "stall");

        // start held high across done restarts from IDLE
        push_beats(8'hAA, 32'h9000_F020);
        push_beats(8'hAA, 32'h9000_F020);
        @(posedge clk); #1;
        Lc = 20'h08CA7; Lp = 20'h13C09; start = 1'b1; c0 = cyc;
        push_done(1'b0, c0 + NR + 1 + LAT);
        push_done(1'b0, c0 + 2 * (NR + 1 + LAT) + 1);
        n = 0;
        while (done_cnt < 3 && n < 100) begin @(posedge clk); n++; end
        chk("held_first_done", done_cnt >= 3, 1'b1);
        #1;
        chk("busy_drop_after_done", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; Lc = 20'hFFFFF; Lp = 20'hFFFFF;
        wait_done(4, "held_second");

`ifdef CHALLENGE_CHECK_EN
        kick(20'h084A7, 20'h21800, c0);
        push_done(1'b1, c0 + 2);
        wait_done(5, "dup_reject");
        chk("err_sticky", err, 1'b1);
        kick(20'h40022, 20'h13C09, c0);
        push_done(1'b1, c0 + 2);
        wait_done(6, "range_reject");
        kick(20'h08CA7, 20'h83C09, c0);
        push_done(1'b1, c0 + 2);
        wait_done(7, "party_reject");
        push_beats(8'hAA, 32'h9000_F020);
        kick(20'h08CA7, 20'h13C09, c0);
        chk("err_cleared_on_start", err, 1'b0);
        push_done(1'b0, c0 + NR + 1 + LAT);
        wait_done(8, "after_reject");
`else
        push_beats(8'hA2, 32'h0000_0040);
        kick(20'h084A7, 20'h21800, c0);
        push_done(1'b0, c0 + NR + 1);
        wait_done(5, "dup_entries");
        push_beats(8'h07, 32'h0000_090F);
        kick(20'h40022, 20'h13C09, c0);
        push_done(1'b0, c0 + NR + 1);
        wait_done(6, "range_entries");
        push_beats(8'hAA, 32'h9000_F000);
        kick(20'h08CA7, 20'h83C09, c0);
        push_done(1'b0, c0 + NR + 1);
        wait_done(7, "wide_party");
        push_beats(8'hAA, 32'h9000_F020);
        kick(20'h08CA7, 20'h13C09, c0);
        push_done(1'b0, c0 + NR + 1);
        wait_done(8, "repeat_basic");
`endif

        // Reset during round 4 aborts with no done; a fresh run then completes
        push_beats(8'hAA, 32'h9000_F020);
        kick(20'h08CA7, 20'h13C09, c0);
        wait_round(5'd4, "reach_round4");
        reset = 1'b1; out_ready = 1'b0;
        exp_beat.delete();
        exp_done.delete();
        saved = done_cnt;
        @(posedge clk); #1;
        chk_zero("abort");
        reset = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_cnt, saved);
        push_beats(8'hAA, 32'h9000_F020);
        kick(20'h08CA7, 20'h13C09, c0);
        push_done(1'b0, c0 + NR + 1 + LAT);
        wait_done(saved + 1, "post_reset");
        chk("queue_drained", exp_beat.size() + exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
